ci_band_power: RTL and testbench
================================

Name: ci_band_power

Overview:
- Sits directly downstream of the FFT handler in the EEG signal path.
- Consumes the stream of real FFT bin values and squares each one.
- Sums the squares over four contiguous bin ranges (delta/theta/alpha/beta) per frame.
- Emits one power word per band plus an end-of-frame strobe for the display/host interface stage.

Parameters:
- DATLEN, 12, width of incoming FFT real value (two's complement)
- FFT_LEN, 16, bins per frame; bin counter wraps at FFT_LEN-1
- ACC_W, 28, width of band power accumulator/output
- B0_LO, 1, first bin of band 0 (DC bin 0 excluded by default)
- B0_HI, 2, last bin of band 0
- B1_LO, 3, first bin of band 1
- B1_HI, 4, last bin of band 1
- B2_LO, 5, first bin of band 2
- B2_HI, 6, last bin of band 2
- B3_LO, 7, first bin of band 3
- B3_HI, 8, last bin of band 3
- Band ranges are ascending and non-overlapping, and all lie below FFT_LEN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- nd  in  1  new FFT bin present on real_in (driven from FFT out_nd)
- real_in  in  DATLEN  signed real part of current bin
- resync  in  1  one-cycle pulse: next bin is bin 0 of a new frame; discards partial sums
- fft_overflow  in  1  FFT overflow indication
- band_valid  out  1  one-cycle strobe: band_id/band_pow valid
- band_id  out  2  band index 0..3
- band_pow  out  ACC_W  sum of squares for band
- frame_done  out  1  one-cycle strobe after bin FFT_LEN-1 processed
- ovf_seen  out  1  sticky: fft_overflow was high on any cycle since reset

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: all outputs 0; bin counter 0; accumulator 0; pipeline valids 0.
- Stage 0 (bin counter):
  - On nd, current bin = bin_cnt.
  - bin_cnt increments, wrapping FFT_LEN-1 -> 0.
  - bin_cnt holds when nd is low.
- Stage 1 (registered), on nd:
  - sq_r <= real_in*real_in, unsigned, 2*DATLEN-1 bits significant.
  - Max is (-2048)^2 = 2^22.
  - bin_r <= current bin; v1 <= 1. Otherwise v1 <= 0.
- Stage 2, when v1 and bin_r lies in band k:
  - If bin_r == Bk_LO: acc <= sq_r; otherwise acc <= acc + sq_r.
  - If bin_r == Bk_HI (including Bk_LO == Bk_HI):
    - band_pow <= the acc value just formed, i.e. (bin_r == Bk_LO ? 0 : acc) + sq_r.
    - band_id <= k; band_valid <= 1 for exactly one cycle.
- Bins outside all bands are ignored; acc is untouched.
- Stage 2, when v1 and bin_r == FFT_LEN-1: frame_done <= 1 for one cycle.
  - If FFT_LEN-1 == B3_HI, band_valid and frame_done pulse in the same cycle.
- Latency: band_valid / frame_done assert 2 cycles after the nd cycle carrying the closing bin.
- Throughput: nd may be high every cycle; no backpressure and no stalls.
- Width: ACC_W >= 2*DATLEN-1 + clog2(max band width). The default of 28 has margin.
  - Saturate acc at all-ones instead of wrapping (defensive).
- resync:
  - resync pulse: bin_cnt <= 0; v1 <= 0; acc <= 0.
  - Any pending stage-1 data is dropped, with no band_valid or frame_done for it.
- resync and nd in the same cycle: that nd sample is bin 0 of the new frame (is registered into stage 1 with bin_r = 0). The stage-1 sample in flight is dropped.
- ovf_seen:
  - Sets on any cycle with fft_overflow = 1.
  - Cleared only by reset; resync does not clear it.
- Reset mid-frame: everything returns to reset values, and the next nd is bin 0.
- Reset has priority over resync and nd.

Decomposition:
- Shared package ci_pkg holds:
  - the DATLEN constant (12), shared with the ADC/FFT path;
  - FFT_LEN (16);
  - band-id encoding (BAND_DELTA=0, BAND_THETA=1, BAND_ALPHA=2, BAND_BETA=3);
  - default band boundaries.
- One natural sub-module: ci_band_lookup. It is combinational: bin index -> {in_band, band_k, is_lo, is_hi}.
  - This keeps the range compares out of the datapath.

Test Plan:
- Reset, then 16 consecutive nd with real_in=0 -> four band_valid strobes (ids 0,1,2,3, pow 0) and one frame_done, each 2 cycles after bins 2,4,6,8 and 15 respectively.
- One frame with real_in=bin index (0..15) -> band_pow 0:1+4=5, 1:9+16=25, 2:25+36=61, 3:49+64=113.
- real_in=-2048 on all 16 bins -> every band_pow = 2*4194304 = 8388608. Checks signed squaring.
- nd gapped (one nd every 3 cycles) across one frame -> same values as the contiguous case; strobes 2 cycles after the closing nd.
- Mid-frame resync after bin 5, then 16 bins of value 1:
  - bands 0 and 1 from the aborted frame were already reported;
  - no band-2 report for the aborted frame;
  - the new frame reports pow 2,2,2,2 and frame_done.
- fft_overflow pulsed 1 cycle -> ovf_seen stays 1 through a resync; it clears only after reset.

Source files
------------

// File: rtl/ci_pkg.sv
// Constants and types shared by the EEG path: sample width, FFT length,
// band-id encoding and the default delta/theta/alpha/beta bin boundaries.
package ci_pkg;

    localparam int DATLEN    = 12;
    localparam int FFT_LEN   = 16;
    localparam int ACC_W_DEF = 28;

    typedef enum logic [1:0] {
        BAND_DELTA = 2'd0,
        BAND_THETA = 2'd1,
        BAND_ALPHA = 2'd2,
        BAND_BETA  = 2'd3
    } band_e;

    localparam int B0_LO_DEF = 1;
    localparam int B0_HI_DEF = 2;
    localparam int B1_LO_DEF = 3;
    localparam int B1_HI_DEF = 4;
    localparam int B2_LO_DEF = 5;
    localparam int B2_HI_DEF = 6;
    localparam int B3_LO_DEF = 7;
    localparam int B3_HI_DEF = 8;

    typedef struct packed {
        logic  in_band;
        band_e band_k;
        logic  is_lo;
        logic  is_hi;
    } band_hit_t;

endpackage

// File: rtl/ci_band_lookup.sv
// Combinational bin-index classifier: which band a bin belongs to and
// whether it opens or closes that band.
module ci_band_lookup
    import ci_pkg::*;
#(
    parameter int BIN_W = 4,
    parameter int B0_LO = ci_pkg::B0_LO_DEF,
    parameter int B0_HI = ci_pkg::B0_HI_DEF,
    parameter int B1_LO = ci_pkg::B1_LO_DEF,
    parameter int B1_HI = ci_pkg::B1_HI_DEF,
    parameter int B2_LO = ci_pkg::B2_LO_DEF,
    parameter int B2_HI = ci_pkg::B2_HI_DEF,
    parameter int B3_LO = ci_pkg::B3_LO_DEF,
    parameter int B3_HI = ci_pkg::B3_HI_DEF
) (
    input  logic [BIN_W-1:0] bin,
    output band_hit_t        hit
);

    localparam int LO [4] = '{B0_LO, B1_LO, B2_LO, B3_LO};
    localparam int HI [4] = '{B0_HI, B1_HI, B2_HI, B3_HI};

    int bin_i;
    assign bin_i = int'(bin);

    // NOTE: every field gets a default before the search loop so no path
    // through the block leaves hit unassigned, which would infer a latch.
    always_comb begin
        hit = '0;
        for (int k = 0; k < 4; k++) begin
            if (bin_i >= LO[k] && bin_i <= HI[k]) begin
                hit.in_band = 1'b1;
                hit.band_k  = band_e'(k[1:0]);
                hit.is_lo   = (bin_i == LO[k]);
                hit.is_hi   = (bin_i == HI[k]);
            end
        end
    end

endmodule

// File: rtl/ci_band_power.sv
// Squares each real FFT bin and sums the squares over four contiguous bin
// ranges per frame, emitting one power word per band and an end-of-frame strobe.
module ci_band_power #(
    parameter int DATLEN  = ci_pkg::DATLEN,
    parameter int FFT_LEN = ci_pkg::FFT_LEN,
    parameter int ACC_W   = ci_pkg::ACC_W_DEF,
    parameter int B0_LO   = ci_pkg::B0_LO_DEF,
    parameter int B0_HI   = ci_pkg::B0_HI_DEF,
    parameter int B1_LO   = ci_pkg::B1_LO_DEF,
    parameter int B1_HI   = ci_pkg::B1_HI_DEF,
    parameter int B2_LO   = ci_pkg::B2_LO_DEF,
    parameter int B2_HI   = ci_pkg::B2_HI_DEF,
    parameter int B3_LO   = ci_pkg::B3_LO_DEF,
    parameter int B3_HI   = ci_pkg::B3_HI_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     nd,
    input  logic signed [DATLEN-1:0] real_in,
    input  logic                     resync,
    input  logic                     fft_overflow,
    output logic                     band_valid,
    output logic [1:0]               band_id,
    output logic [ACC_W-1:0]         band_pow,
    output logic                     frame_done,
    output logic                     ovf_seen
);

    import ci_pkg::*;

    localparam int               BIN_W    = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
    localparam int               SQ_W     = 2 * DATLEN;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);

    logic [BIN_W-1:0]       bin_cnt;
    logic [BIN_W-1:0]       cur_bin;
    logic [BIN_W-1:0]       bin_r;
    logic                   v1;
    logic signed [SQ_W-1:0] real_ext;
    logic signed [SQ_W-1:0] prod;
    logic [SQ_W-1:0]        sq_r;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_base;
    logic [ACC_W:0]         acc_sum;
    logic [ACC_W-1:0]       acc_next;
    band_hit_t              hit;

    // A resync in the same cycle as nd makes that sample bin 0 of the new frame.
    assign cur_bin  = resync ? '0 : bin_cnt;

    assign real_ext = SQ_W'(real_in);
    assign prod     = real_ext * real_ext;

    assign acc_base = hit.is_lo ? '0 : acc;
    assign acc_sum  = {1'b0, acc_base} + (ACC_W + 1)'(sq_r);
    assign acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

    ci_band_lookup #(
        .BIN_W (BIN_W),
        .B0_LO (B0_LO), .B0_HI (B0_HI),
        .B1_LO (B1_LO), .B1_HI (B1_HI),
        .B2_LO (B2_LO), .B2_HI (B2_HI),
        .B3_LO (B3_LO), .B3_HI (B3_HI)
    ) u_lookup (
        .bin (bin_r),
        .hit (hit)
    );

    // NOTE: non-blocking assignments throughout, so every stage reads the
    // previous cycle's value of the stage before it regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_cnt    <= '0;
            bin_r      <= '0;
            sq_r       <= '0;
            v1         <= 1'b0;
            acc        <= '0;
            band_valid <= 1'b0;
            band_id    <= '0;
            band_pow   <= '0;
            frame_done <= 1'b0;
            ovf_seen   <= 1'b0;
        end else begin
            band_valid <= 1'b0;
            frame_done <= 1'b0;
            v1         <= nd;

            if (fft_overflow) begin
                ovf_seen <= 1'b1;
            end

            if (resync) begin
                bin_cnt <= '0;
                acc     <= '0;
            end

            if (nd) begin
                bin_cnt <= (cur_bin == LAST_BIN) ? '0 : cur_bin + 1'b1;
                bin_r   <= cur_bin;
                sq_r    <= prod;
            end

            // The stage-1 sample in flight during a resync is discarded.
            if (v1 && !resync) begin
                if (hit.in_band) begin
                    acc <= acc_next;
                    if (hit.is_hi) begin
                        band_valid <= 1'b1;
                        band_id    <= hit.band_k;
                        band_pow   <= acc_next;
                    end
                end
                if (bin_r == LAST_BIN) begin
                    frame_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ci_band_power.sv
// Self-checking bench for ci_band_power: table-driven frames, resync/reset
// corner sequences and randomized traffic against a frame-level reference model.
module tb_ci_band_power;

    localparam int ACC_W = 28;

    logic               clk = 1'b0;
    logic               reset;
    logic               nd;
    logic signed [11:0] real_in;
    logic               resync;
    logic               fft_overflow;
    logic               band_valid;
    logic [1:0]         band_id;
    logic [ACC_W-1:0]   band_pow;
    logic               frame_done;
    logic               ovf_seen;

    always #5 clk = ~clk;

    ci_band_power dut (
        .clk          (clk),
        .reset        (reset),
        .nd           (nd),
        .real_in      (real_in),
        .resync       (resync),
        .fft_overflow (fft_overflow),
        .band_valid   (band_valid),
        .band_id      (band_id),
        .band_pow     (band_pow),
        .frame_done   (frame_done),
        .ovf_seen     (ovf_seen)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    int LO [4] = '{1, 3, 5, 7};
    int HI [4] = '{2, 4, 6, 8};

    typedef struct {
        int     edge_no;
        bit     is_frame;
        int     id;
        longint pow;
    } evt_t;

    typedef struct {
        bit nd;
        int val;
        bit rs;
    } stim_t;

    typedef struct {
        string name;
        int    pattern;
        int    gap;
        int    pow [4];
    } vec_t;

    evt_t  obs_q [$];
    evt_t  exp_q [$];
    stim_t stim  [$];

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (band_valid === 1'b1)
            obs_q.push_back(evt_t'{edge_cnt, 1'b0, int'(band_id), longint'(band_pow)});
        if (frame_done === 1'b1)
            obs_q.push_back(evt_t'{edge_cnt, 1'b1, 0, 0});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit n, input int v, input bit r);
        stim.push_back(stim_t'{n, v, r});
    endtask

    task automatic idle_inputs();
        nd = 1'b0; real_in = '0; resync = 1'b0; fft_overflow = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        idle_inputs();
        repeat (cycles) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    // Frame-level reference: tracks the bin index of each accepted sample,
    // keeps its square per bin and reports a band sum when the closing bin lands.
    task automatic model(input int start);
        int     cnt = 0;
        int     b;
        longint sq [16] = '{default: 0};
        longint sum;
        exp_q.delete();
        for (int i = 0; i < stim.size(); i++) begin
            if (stim[i].rs) cnt = 0;
            if (stim[i].nd) begin
                b   = cnt;
                cnt = (cnt + 1) % 16;
                if (i + 1 < stim.size() && stim[i + 1].rs) continue;
                sq[b] = longint'(stim[i].val) * longint'(stim[i].val);
                for (int k = 0; k < 4; k++) begin
                    if (b == HI[k]) begin
                        sum = 0;
                        for (int j = LO[k]; j <= HI[k]; j++) sum += sq[j];
                        exp_q.push_back(evt_t'{start + i + 2, 1'b0, k, sum});
                    end
                end
                if (b == 15) exp_q.push_back(evt_t'{start + i + 2, 1'b1, 0, 0});
            end
        end
    endtask

    // Drives the queued stimulus one cycle per entry; returns the edge count
    // before the first sampling edge so the model can time its events.
    task automatic run(input bit pad, output int start);
        obs_q.delete();
        start = edge_cnt;
        for (int i = 0; i < stim.size(); i++) begin
            nd      = stim[i].nd;
            real_in = 12'(stim[i].val);
            resync  = stim[i].rs;
            @(posedge clk); #1;
        end
        idle_inputs();
        if (pad) begin
            repeat (4) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ev%0d_cycle", tag, i), obs_q[i].edge_no, exp_q[i].edge_no);
            check($sformatf("%s_ev%0d_kind", tag, i), obs_q[i].is_frame, exp_q[i].is_frame);
            check($sformatf("%s_ev%0d_id", tag, i), obs_q[i].id, exp_q[i].id);
            check($sformatf("%s_ev%0d_pow", tag, i), obs_q[i].pow, exp_q[i].pow);
        end
    endtask

    function automatic int pattern_val(input int pattern, input int bin);
        case (pattern)
            1:       return bin;
            2:       return -2048;
            default: return 0;
        endcase
    endfunction

    initial begin
        vec_t tbl [4];
        int   start;
        int   seen;
        int   want_id [6] = '{0, 1, 0, 1, 2, 3};

        tbl[0] = vec_t'{"zeros",   0, 1, '{0, 0, 0, 0}};
        tbl[1] = vec_t'{"ramp",    1, 1, '{5, 25, 61, 113}};
        tbl[2] = vec_t'{"neg_max", 2, 1, '{8388608, 8388608, 8388608, 8388608}};
        tbl[3] = vec_t'{"gapped",  1, 3, '{5, 25, 61, 113}};

        do_reset(3);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_band_valid", band_valid, 0);
        check("rst_band_id", band_id, 0);
        check("rst_band_pow", band_pow, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_ovf_seen", ovf_seen, 0);
        reset = 1'b0;

        for (int t = 0; t < 4; t++) begin
            stim.delete();
            for (int b = 0; b < 16; b++) begin
                add(1'b1, pattern_val(tbl[t].pattern, b), 1'b0);
                for (int g = 1; g < tbl[t].gap; g++) add(1'b0, 0, 1'b0);
            end
            run(1'b1, start);
            seen = 0;
            foreach (obs_q[i]) begin
                if (!obs_q[i].is_frame) begin
                    check($sformatf("%s_band%0d_pow", tbl[t].name, obs_q[i].id),
                          obs_q[i].pow, tbl[t].pow[obs_q[i].id]);
                    seen++;
                end
            end
            check({tbl[t].name, "_band_reports"}, seen, 4);
            model(start);
            compare(tbl[t].name);
        end

        // Resync after bin 5, then a full frame of ones.
        stim.delete();
        for (int b = 0; b < 6; b++) add(1'b1, 1, 1'b0);
        add(1'b0, 0, 1'b1);
        for (int b = 0; b < 16; b++) add(1'b1, 1, 1'b0);
        run(1'b1, start);
        check("resync_count", obs_q.size(), 7);
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            check($sformatf("resync_ev%0d_id", i), obs_q[i].id, want_id[i]);
            check($sformatf("resync_ev%0d_pow", i), obs_q[i].pow, 2);
        end
        if (obs_q.size() == 7) check("resync_frame_done", obs_q[6].is_frame, 1);
        model(start);
        compare("resync");

        // Reset mid-frame: the next nd must be bin 0 again.
        stim.delete();
        for (int b = 0; b < 4; b++) add(1'b1, 7, 1'b0);
        run(1'b0, start);
        model(start);
        do_reset(2);
        compare("pre_reset");
        stim.delete();
        for (int b = 0; b < 16; b++) add(1'b1, 1, 1'b0);
        run(1'b1, start);
        model(start);
        compare("post_reset");

        // Randomized traffic with gaps and occasional resync (some coinciding with nd).
        do_reset(2);
        stim.delete();
        for (int i = 0; i < 800; i++) begin
            add($urandom_range(0, 9) < 7, int'($urandom_range(0, 4095)) - 2048,
                $urandom_range(0, 99) < 3);
        end
        run(1'b1, start);
        model(start);
        compare("rand");

        // Sticky overflow flag survives resync, clears on reset.
        check("ovf_before", ovf_seen, 0);
        fft_overflow = 1'b1;
        @(posedge clk); #1;
        fft_overflow = 1'b0;
        check("ovf_set", ovf_seen, 1);
        @(posedge clk); #1;
        check("ovf_hold", ovf_seen, 1);
        resync = 1'b1;
        @(posedge clk); #1;
        resync = 1'b0;
        @(posedge clk); #1;
        check("ovf_after_resync", ovf_seen, 1);
        do_reset(1);
        check("ovf_after_reset", ovf_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
